// File: rtl/key_click_decoder_pkg.sv
// Shared definitions for key_click_decoder: FSM state encodings and the gap window lengths.
package key_click_decoder_pkg;

    localparam int WIN_W = 24;

    // 300 ms at 50 MHz; the short value keeps simulations quick.
    localparam logic [WIN_W-1:0] CNT_WIN_DEFAULT = 24'd14_999_999;
    localparam logic [WIN_W-1:0] CNT_WIN_SIM     = 24'd20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ONE  = 2'd1,
        ST_TWO  = 2'd2
    } state_e;

endpackage

// File: rtl/key_click_decoder_win_timer.sv
// Gap window timer: restarts on clear, counts while enabled, done when the window has fully elapsed.
module key_win_timer
    import key_click_decoder_pkg::*;
#(
    parameter logic [WIN_W-1:0] CNT_WIN_MAX = CNT_WIN_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    logic [WIN_W-1:0] cnt_q;
    logic [WIN_W-1:0] cnt_d;

    assign done = (cnt_q == CNT_WIN_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !enable) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_click_decoder.sv
// Classifies bursts of key_flag presses into single/double (and triple) click pulses.
// Optional feature: define TRIPLE_CLICK_EN to add the TWO state and drive triple_flag.
module key_click_decoder
    import key_click_decoder_pkg::*;
#(
    parameter logic [WIN_W-1:0] CNT_WIN_MAX = CNT_WIN_DEFAULT
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flag,
    output logic single_flag,
    output logic double_flag,
    output logic triple_flag,
    output logic busy
);

    state_e state_q;
    state_e state_d;
    logic   single_q, single_d;
    logic   double_q, double_d;
    logic   busy_q,   busy_d;
    logic   win_done;
    logic   win_clr;
    logic   win_en;

    // A press always restarts the window; an expiry clears it as the burst closes.
    assign win_clr = key_flag | win_done;
    assign win_en  = (state_q != ST_IDLE);

    key_win_timer #(
        .CNT_WIN_MAX (CNT_WIN_MAX)
    ) u_win_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (win_clr),
        .enable    (win_en),
        .done      (win_done)
    );

`ifdef TRIPLE_CLICK_EN
    logic triple_q, triple_d;
`endif

    always_comb begin
        state_d  = state_q;
        single_d = 1'b0;
        double_d = 1'b0;
`ifdef TRIPLE_CLICK_EN
        triple_d = 1'b0;
`endif
        // A press on the expiry edge takes priority and counts as the next click.
        case (state_q)
            ST_IDLE: begin
                if (key_flag) state_d = ST_ONE;
            end
            ST_ONE: begin
                if (key_flag) begin
`ifdef TRIPLE_CLICK_EN
                    state_d = ST_TWO;
`else
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
`endif
                end else if (win_done) begin
                    single_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
`ifdef TRIPLE_CLICK_EN
            ST_TWO: begin
                if (key_flag) begin
                    triple_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (win_done) begin
                    double_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= ST_IDLE;
            single_q <= 1'b0;
            double_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            single_q <= single_d;
            double_q <= double_d;
            busy_q   <= busy_d;
        end
    end

`ifdef TRIPLE_CLICK_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            triple_q <= 1'b0;
        end else begin
            triple_q <= triple_d;
        end
    end
    assign triple_flag = triple_q;
`else
    assign triple_flag = 1'b0;
`endif

    assign single_flag = single_q;
    assign double_flag = double_q;
    assign busy        = busy_q;

endmodule
